regfile_scoreboard: RTL and testbench

Parametrised multi-read register file with same-cycle write forwarding and a per-register pending scoreboard. It is the next-generation CPU register file. It adds configurable data width and depth, an asynchronous clear, write-to-read bypass, and busy tracking so the decode stage can detect read-after-write hazards. It sits between decode (read/issue ports) and writeback (write port).

---
 rtl/regfile_scoreboard.sv | 97 +++++++++
 tb/tb_regfile_scoreboard.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_scoreboard.sv
// Multi-read register file with same-cycle write forwarding and a per-register
// pending scoreboard that lets decode detect read-after-write hazards.
module regfile_scoreboard #(
   parameter int DATA_W   = 8,
   parameter int ADDR_W   = 2,
   parameter bit ZERO_REG = 1'b1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] rd_addr_a,
   input  logic [ADDR_W-1:0] rd_addr_b,
   output logic [DATA_W-1:0] rd_data_a,
   output logic [DATA_W-1:0] rd_data_b,
   output logic              busy_a,
   output logic              busy_b,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              iss_en,
   input  logic [ADDR_W-1:0] iss_addr,
   output logic              any_pending
);

   localparam int DEPTH = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
   localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

   logic [DATA_W-1:0] data_r [DEPTH];
   logic [DEPTH-1:0]  pending_r;
   logic [DEPTH-1:0]  pending_nxt_s;
   logic              wr_ok_s;
   logic              iss_ok_s;

   // A hardwired zero register swallows both writebacks and issues
   assign wr_ok_s  = wr_en  & ~(ZERO_REG & (wr_addr  == ADDR_ZERO));
   assign iss_ok_s = iss_en & ~(ZERO_REG & (iss_addr == ADDR_ZERO));

   // Next pending vector; on a same-address collision the issue's set wins
   always_comb begin
      pending_nxt_s = pending_r;
      case ({wr_ok_s, iss_ok_s})
         2'b10: pending_nxt_s[wr_addr] = 1'b0;
         2'b01: pending_nxt_s[iss_addr] = 1'b1;
         2'b11: begin
            pending_nxt_s[wr_addr]  = 1'b0;
            pending_nxt_s[iss_addr] = 1'b1;
         end
         default: pending_nxt_s = pending_r;
      endcase
   end

   // Data array and scoreboard state with asynchronous clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            data_r[i] <= DATA_ZERO;
         end
         pending_r <= {DEPTH{1'b0}};
      end else begin
         if (wr_ok_s) begin
            data_r[wr_addr] <= wr_data;
         end
         pending_r <= pending_nxt_s;
      end
   end

   // Read port A: zero register, then forward from writeback, then array
   always_comb begin
      if (ZERO_REG && (rd_addr_a == ADDR_ZERO)) begin
         rd_data_a = DATA_ZERO;
         busy_a    = 1'b0;
      end else if (wr_en && (wr_addr == rd_addr_a)) begin
         rd_data_a = wr_data;
         busy_a    = 1'b0;
      end else begin
         rd_data_a = data_r[rd_addr_a];
         busy_a    = pending_r[rd_addr_a];
      end
   end

   // Read port B: same priority as port A
   always_comb begin
      if (ZERO_REG && (rd_addr_b == ADDR_ZERO)) begin
         rd_data_b = DATA_ZERO;
         busy_b    = 1'b0;
      end else if (wr_en && (wr_addr == rd_addr_b)) begin
         rd_data_b = wr_data;
         busy_b    = 1'b0;
      end else begin
         rd_data_b = data_r[rd_addr_b];
         busy_b    = pending_r[rd_addr_b];
      end
   end

   assign any_pending = |pending_r;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Scoreboard bench for regfile_scoreboard: two instances (8b/4 regs with zero
// register, 32b/32 regs without) checked against an array-based reference.
module tb_regfile_scoreboard;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;
   logic        we [2];
   logic        ie [2];
   logic [4:0]  wa [2];
   logic [4:0]  ia [2];
   logic [4:0]  raa [2];
   logic [4:0]  rab [2];
   logic [31:0] wd [2];

   logic [7:0]  rda0, rdb0;
   logic [31:0] rda1, rdb1;
   logic        ba0, bb0, ap0, ba1, bb1, ap1;

   regfile_scoreboard #(.DATA_W(8), .ADDR_W(2), .ZERO_REG(1'b1)) u_dut0 (
      .clk(clk), .rst_n(rst_n),
      .rd_addr_a(raa[0][1:0]), .rd_addr_b(rab[0][1:0]),
      .rd_data_a(rda0), .rd_data_b(rdb0),
      .busy_a(ba0), .busy_b(bb0),
      .wr_en(we[0]), .wr_addr(wa[0][1:0]), .wr_data(wd[0][7:0]),
      .iss_en(ie[0]), .iss_addr(ia[0][1:0]),
      .any_pending(ap0)
   );

   regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .rd_addr_a(raa[1]), .rd_addr_b(rab[1]),
      .rd_data_a(rda1), .rd_data_b(rdb1),
      .busy_a(ba1), .busy_b(bb1),
      .wr_en(we[1]), .wr_addr(wa[1]), .wr_data(wd[1]),
      .iss_en(ie[1]), .iss_addr(ia[1]),
      .any_pending(ap1)
   );

   int          amax [2]  = '{3, 31};
   logic [31:0] dmask [2] = '{32'h0000_00FF, 32'hFFFF_FFFF};
   bit          zr [2]    = '{1'b1, 1'b0};

   // Reference state: plain arrays of register values and pending flags
   logic [31:0] mem [2][32];
   bit          pend [2][32];

   typedef struct {
      int          k;
      logic [31:0] da;
      logic [31:0] db;
      logic        ba;
      logic        bb;
      logic        ap;
   } exp_t;
   exp_t q[$];

   int errors = 0;
   int checks = 0;

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endfunction

   function automatic void model_read(input int k, input int ra,
                                      output logic [31:0] d, output logic b);
      if (zr[k] && ra == 0) begin
         d = 32'h0; b = 1'b0;
      end else if (we[k] && int'(wa[k]) == ra) begin
         d = wd[k] & dmask[k]; b = 1'b0;
      end else begin
         d = mem[k][ra]; b = pend[k][ra];
      end
   endfunction

   function automatic void model_clear();
      for (int k = 0; k < 2; k++)
         for (int r = 0; r < 32; r++) begin
            mem[k][r]  = 32'h0;
            pend[k][r] = 1'b0;
         end
   endfunction

   // One cycle: predict outputs for the current inputs, then apply the edge
   task automatic step();
      exp_t e;
      if (!rst_n) model_clear();
      for (int k = 0; k < 2; k++) begin
         e.k = k;
         model_read(k, int'(raa[k]), e.da, e.ba);
         model_read(k, int'(rab[k]), e.db, e.bb);
         e.ap = 1'b0;
         for (int r = 0; r <= amax[k]; r++) e.ap = e.ap | pend[k][r];
         q.push_back(e);
      end
      @(posedge clk);
      if (rst_n) begin
         for (int k = 0; k < 2; k++) begin
            if (we[k] && !(zr[k] && wa[k] == 5'd0)) begin
               mem[k][wa[k]]  = wd[k] & dmask[k];
               pend[k][wa[k]] = 1'b0;
            end
            if (ie[k] && !(zr[k] && ia[k] == 5'd0)) pend[k][ia[k]] = 1'b1;
         end
      end
      #1;
   endtask

   task automatic idle();
      for (int k = 0; k < 2; k++) begin
         we[k] = 1'b0; ie[k] = 1'b0;
      end
   endtask

   task automatic rand_inputs();
      for (int k = 0; k < 2; k++) begin
         we[k]  = 1'($urandom_range(0, 1));
         ie[k]  = 1'($urandom_range(0, 1));
         wa[k]  = 5'($urandom_range(0, amax[k]));
         ia[k]  = 5'($urandom_range(0, amax[k]));
         raa[k] = 5'($urandom_range(0, amax[k]));
         rab[k] = 5'($urandom_range(0, amax[k]));
         wd[k]  = $urandom & dmask[k];
      end
   endtask

   // Monitor: compares every predicted cycle at the falling edge
   always @(negedge clk) begin
      exp_t e;
      while (q.size() > 0) begin
         e = q.pop_front();
         if (e.k == 0) begin
            chk("rd_data_a[0]", {24'h0, rda0}, e.da);
            chk("rd_data_b[0]", {24'h0, rdb0}, e.db);
            chk("busy_a[0]", {31'h0, ba0}, {31'h0, e.ba});
            chk("busy_b[0]", {31'h0, bb0}, {31'h0, e.bb});
            chk("any_pending[0]", {31'h0, ap0}, {31'h0, e.ap});
         end else begin
            chk("rd_data_a[1]", rda1, e.da);
            chk("rd_data_b[1]", rdb1, e.db);
            chk("busy_a[1]", {31'h0, ba1}, {31'h0, e.ba});
            chk("busy_b[1]", {31'h0, bb1}, {31'h0, e.bb});
            chk("any_pending[1]", {31'h0, ap1}, {31'h0, e.ap});
         end
      end
   end

   initial begin
      rst_n = 1'b0;
      for (int k = 0; k < 2; k++) begin
         we[k] = 1'b0; ie[k] = 1'b0; wa[k] = 5'd0; ia[k] = 5'd0;
         raa[k] = 5'd0; rab[k] = 5'd0; wd[k] = 32'h0;
      end
      model_clear();
      @(posedge clk); #1;
      step(); step();
      rst_n = 1'b1;
      raa[0] = 5'd1; rab[0] = 5'd3; raa[1] = 5'd7; rab[1] = 5'd31;
      step();

      // Forwarding then array readback
      we[0] = 1'b1; wa[0] = 5'd2; wd[0] = 32'hA5; raa[0] = 5'd2;
      step();
      idle(); step();

      // Register 0: hardwired in instance 0, ordinary in instance 1
      for (int k = 0; k < 2; k++) begin
         we[k] = 1'b1; wa[k] = 5'd0; wd[k] = 32'hFF;
         ie[k] = 1'b1; ia[k] = 5'd0; raa[k] = 5'd0;
      end
      step();
      idle(); step(); step();

      // Issue to 3, then writeback 0x3C to 3
      ie[0] = 1'b1; ia[0] = 5'd3; rab[0] = 5'd3;
      step();
      idle(); step();
      we[0] = 1'b1; wa[0] = 5'd3; wd[0] = 32'h3C;
      step();
      idle(); step();

      // Simultaneous issue and write: same address, then different addresses
      we[0] = 1'b1; ie[0] = 1'b1; wa[0] = 5'd1; ia[0] = 5'd1; wd[0] = 32'h11;
      raa[0] = 5'd1;
      step();
      idle(); step();
      we[0] = 1'b1; wa[0] = 5'd2; wd[0] = 32'h22; ie[0] = 1'b1; ia[0] = 5'd1;
      raa[0] = 5'd1; rab[0] = 5'd2;
      step();
      idle(); step();

      // Sweep all 32 registers of the wide instance
      for (int i = 0; i < 32; i++) begin
         we[1] = 1'b1; wa[1] = 5'(i); wd[1] = 32'hA500_0000 ^ (i * 32'h0101_0101);
         step();
      end
      idle();
      for (int i = 0; i < 32; i++) begin
         raa[1] = 5'(i); rab[1] = 5'(31 - i);
         step();
      end

      // Asynchronous clear in the middle of traffic
      we[1] = 1'b1; wa[1] = 5'd9; wd[1] = 32'hDEAD_BEEF; ie[1] = 1'b1; ia[1] = 5'd4;
      raa[1] = 5'd9; rab[1] = 5'd4;
      rst_n = 1'b0;
      step();
      rst_n = 1'b1; idle();
      for (int i = 0; i < 4; i++) begin
         raa[1] = 5'(i * 8); rab[1] = 5'(i * 8 + 5);
         step();
      end

      // Randomized traffic with occasional reset pulses
      for (int n = 0; n < 400; n++) begin
         rand_inputs();
         rst_n = ($urandom_range(0, 99) < 2) ? 1'b0 : 1'b1;
         step();
      end
      rst_n = 1'b1; idle();
      step();

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      chk("queue_drained", 32'(q.size()), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
